aes_block_cipher: RTL
=====================

# aes_block_cipher

Parametrised iterative AES block cipher: one round per clock, AES-128/192/256 selected at elaboration, encrypt or decrypt per block, valid/ready handshakes on key load, input and output. Round keys are expanded once per key into an internal buffer and reused across blocks. It supersedes the fixed AES-256, encrypt-only, start/done core as the cipher engine beneath the mode wrappers (ECB/CBC/CTR).

## Interface
- KEY_BITS, 256, key length; legal values 128, 192, 256; any other value is an elaboration error
- NK, KEY_BITS/32 (derived localparam), key words
- NR, NK+6 (derived localparam), rounds: 10/12/14
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- key_valid  in  1  key offered
- key_ready  out  1  key accepted when key_valid & key_ready
- key_in  in  KEY_BITS  cipher key, FIPS-197 byte order (byte 0 in MSBs)
- key_loaded  out  1  round-key buffer valid for the current key
- in_valid  in  1  block offered
- in_ready  out  1  block accepted when in_valid & in_ready
- in_data  in  128  plaintext (encrypt) or ciphertext (decrypt)
- in_decrypt  in  1  sampled with in_data; 1 = inverse cipher
- out_valid  out  1  result available
- out_ready  in  1  result consumed when out_valid & out_ready
- out_data  out  128  result

## Operation
- Reset: key_loaded=0, key_ready=1, in_ready=0, out_valid=0, out_data=0; FSM in IDLE; key schedule idle. Reset mid-block or mid-expansion aborts the work; a key must be reloaded.
- Key schedule: on key handshake, words w[0..NK-1] = key_in in one cycle; then one word per cycle for i = NK..4(NR+1)-1. temp = w[i-1]; if i mod NK == 0: temp = SubWord(RotWord(temp)) ^ Rcon[i/NK]; else if NK == 8 and i mod 8 == 4: temp = SubWord(temp); w[i] = w[i-NK] ^ temp. Rcon = 01,02,04,08,10,20,40,80,1b,36 (MSB byte).
- key_loaded drops on the key handshake edge; rises when the final word is written.
- key_ready = 1 only when FSM is IDLE and no expansion is running; keys offered at other times are held off.
- in_ready = key_loaded & FSM IDLE. One block in flight at a time.
- FSM states: IDLE, ROUND, FINAL, HOLD.
  - IDLE -> ROUND on block handshake: state = in_data ^ rk[0] (encrypt) or in_data ^ rk[NR] (decrypt); round counter = 1; mode latched.
  - ROUND, rounds 1..NR-1: encrypt: SubBytes, ShiftRows, MixColumns, ^ rk[r]; decrypt (standard inverse cipher): InvShiftRows, InvSubBytes, ^ rk[NR-r], InvMixColumns. Counter at NR-1 -> FINAL.
  - FINAL: encrypt omits MixColumns, uses rk[NR]; decrypt omits InvMixColumns, uses rk[0]. Result -> out_data; out_valid=1; -> HOLD.
  - HOLD: out_data and out_valid stable until out_ready; on handshake out_valid=0 -> IDLE.
- out_ready is ignored while out_valid = 0.

## Timing
- Block latency: handshake at edge E0; out_valid rises at edge E_NR (10/12/14 cycles); earliest next in_ready is the cycle after the output handshake, so peak throughput is one block per NR+2 cycles.
- Key expansion: key_loaded rises 4(NR+1)-NK edges after the key handshake (40/46/52).
- No combinational path from in_valid/out_ready/key_valid to any ready output.

## Structure
- Package aes_pkg: sbox/inv-sbox functions, xtime/gmul, Rcon table, SubWord/RotWord, (inv)shift-rows and (inv)mix-columns functions, FSM state enum, nr_of(key_bits) function.
- Sub-module aes_key_schedule: word-serial expander plus (NR+1)x128 round-key buffer with combinational read by round index; owns key_ready/key_loaded.
- Top holds FSM, round counter, state register, encrypt/decrypt round mux.

## Test plan
- KEY_BITS=256, key 000102…1f, encrypt 00112233445566778899aabbccddeeff -> 8ea2b7ca516745bfeafc49904b496089, out_valid exactly 14 cycles after accept; key_loaded exactly 52 cycles after key handshake.
- Same key, decrypt 8ea2b7ca… -> 00112233…eeff; then encrypt again without key reload -> same ciphertext.
- KEY_BITS=128 key 000102…0f -> 69c4e0d86a7b0430d8cdb78070b4c55a (latency 10); KEY_BITS=192 key 00…17 -> dda97ca4864cdfe06eaf70a0ec0d7191 (latency 12).
- Backpressure: out_ready low 20 cycles -> out_data/out_valid stable, in_ready=0, key_ready=0 throughout; release -> in_ready high next cycle.
- Key reload: new key all-zero -> in_ready low for 52 cycles, then encrypt zero block -> dc95c078a2408989ad48a21492842087.
- Reset asserted mid-round 7 -> next cycle out_valid=0, in_ready=0, key_loaded=0, key_ready=1; fresh key and block -> correct result.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES arithmetic: GF(2^8) helpers, S-boxes, round transforms, key-schedule
// helpers and the cipher FSM state type.
package aes_pkg;

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_HOLD} aes_state_e;

  function automatic int nr_of(input int key_bits);
    return key_bits / 32 + 6;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) r = gmul(r, p);
      p = gmul(p, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] i;
    i = ginv(x);
    return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return ginv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Byte k of the state lives at [127-8k -: 8]; row r, column c is byte r+4c.
  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = sbox(s[127-8*k -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = inv_sbox(s[127-8*k -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+4-r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
      o[103-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_block_cipher_if.sv
// Key-load, block-input and result channels of the AES cipher engine.
interface aes_block_cipher_if #(parameter int KEY_BITS = 256);
  // Every channel: a transfer happens on a rising edge where valid & ready are both 1;
  // the source holds valid and payload until then, ready never depends on valid.
  logic                key_valid;
  logic                key_ready;
  logic [KEY_BITS-1:0] key_in;
  logic                key_loaded;
  logic                in_valid;
  logic                in_ready;
  logic [127:0]        in_data;
  logic                in_decrypt;
  logic                out_valid;
  logic                out_ready;
  logic [127:0]        out_data;

  modport slave (
    input  key_valid, key_in, in_valid, in_data, in_decrypt, out_ready,
    output key_ready, key_loaded, in_ready, out_valid, out_data
  );

  modport master (
    output key_valid, key_in, in_valid, in_data, in_decrypt, out_ready,
    input  key_ready, key_loaded, in_ready, out_valid, out_data
  );
endinterface

// File: rtl/aes_key_schedule.sv
// Word-serial AES key expander with a round-key buffer read combinationally by round index.
module aes_key_schedule
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                fsm_idle,
  input  logic                key_valid,
  input  logic [KEY_BITS-1:0] key_in,
  output logic                key_ready,
  output logic                key_loaded,
  input  logic [3:0]          rk_idx,
  output logic [127:0]        rk
);
  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_key_schedule: KEY_BITS must be 128, 192 or 256");
  end

  logic [31:0] w_q [NW];
  logic [31:0] w_d [NW];
  logic [5:0]  widx_q, widx_d;
  logic [2:0]  kmod_q, kmod_d;
  logic [3:0]  rci_q, rci_d;
  logic        busy_q, busy_d;
  logic        loaded_q, loaded_d;
  logic [31:0] prev, temp;
  logic        key_fire;
  logic [5:0]  base;

  always_comb begin
    key_ready = fsm_idle & ~busy_q;
    key_fire  = key_valid & key_ready;
    key_loaded = loaded_q;

    prev = w_q[widx_q - 6'd1];
    temp = prev;
    if (kmod_q == 3'd0) temp = sub_word(rot_word(prev)) ^ {rcon(rci_q), 24'h0};
    else if (NK == 8 && kmod_q == 3'd4) temp = sub_word(prev);

    w_d      = w_q;
    widx_d   = widx_q;
    kmod_d   = kmod_q;
    rci_d    = rci_q;
    busy_d   = busy_q;
    loaded_d = loaded_q;
    if (key_fire) begin
      for (int k = 0; k < NK; k++) w_d[k] = key_in[KEY_BITS-1-32*k -: 32];
      widx_d   = 6'(NK);
      kmod_d   = 3'd0;
      rci_d    = 4'd1;
      busy_d   = 1'b1;
      loaded_d = 1'b0;
    end else if (busy_q) begin
      // kmod/rci track i mod NK and i/NK without dividing by 6.
      w_d[widx_q] = w_q[widx_q - 6'(NK)] ^ temp;
      widx_d = widx_q + 6'd1;
      kmod_d = (kmod_q == 3'(NK - 1)) ? 3'd0 : kmod_q + 3'd1;
      if (kmod_q == 3'd0) rci_d = rci_q + 4'd1;
      if (widx_q == 6'(NW - 1)) begin
        busy_d   = 1'b0;
        loaded_d = 1'b1;
      end
    end

    base = {rk_idx, 2'b00};
    rk   = {w_q[base], w_q[base + 6'd1], w_q[base + 6'd2], w_q[base + 6'd3]};
  end

  always_ff @(posedge clk) begin
    w_q <= w_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      widx_q   <= '0;
      kmod_q   <= '0;
      rci_q    <= '0;
      busy_q   <= 1'b0;
      loaded_q <= 1'b0;
    end else begin
      widx_q   <= widx_d;
      kmod_q   <= kmod_d;
      rci_q    <= rci_d;
      busy_q   <= busy_d;
      loaded_q <= loaded_d;
    end
  end

endmodule

// File: rtl/aes_block_cipher.sv
// Iterative AES-128/192/256 engine: one round per clock, encrypt or decrypt per block,
// round keys expanded once per key by aes_key_schedule.
module aes_block_cipher
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 256
) (
  input  logic                clk,
  input  logic                reset,
  aes_block_cipher_if.slave   bus,
  output aes_state_e          dbg_state
);
  localparam int         NR  = nr_of(KEY_BITS);
  localparam logic [3:0] NR4 = 4'(NR);

  aes_state_e   state_q;
  logic [3:0]   round_q;
  logic [127:0] data_q;
  logic         dec_q;
  logic         out_valid_q;
  logic [127:0] out_data_q;

  logic         fsm_idle;
  logic         key_loaded;
  logic         in_ready;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic [127:0] enc_sr, dec_sb, round_res;

  assign fsm_idle = (state_q == S_IDLE);

  // A source must not offer a key in the same cycle it hands over a block,
  // since the new key would overwrite the buffer the block is using.
  aes_key_schedule #(.KEY_BITS(KEY_BITS)) u_key_schedule (
    .clk        (clk),
    .reset      (reset),
    .fsm_idle   (fsm_idle),
    .key_valid  (bus.key_valid),
    .key_in     (bus.key_in),
    .key_ready  (bus.key_ready),
    .key_loaded (key_loaded),
    .rk_idx     (rk_idx),
    .rk         (rk)
  );

  always_comb begin
    in_ready = key_loaded & fsm_idle;
    rk_idx   = round_q;
    if (fsm_idle) rk_idx = bus.in_decrypt ? NR4 : 4'd0;
    else if (dec_q) rk_idx = NR4 - round_q;

    enc_sr = shift_rows(sub_bytes(data_q));
    dec_sb = inv_sub_bytes(inv_shift_rows(data_q));
    if (state_q == S_FINAL) round_res = dec_q ? (dec_sb ^ rk) : (enc_sr ^ rk);
    else round_res = dec_q ? inv_mix_columns(dec_sb ^ rk) : (mix_columns(enc_sr) ^ rk);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      round_q     <= '0;
      data_q      <= '0;
      dec_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid && in_ready) begin
            data_q  <= bus.in_data ^ rk;
            round_q <= 4'd1;
            dec_q   <= bus.in_decrypt;
            state_q <= S_ROUND;
          end
        end
        S_ROUND: begin
          data_q  <= round_res;
          round_q <= round_q + 4'd1;
          if (round_q == NR4 - 4'd1) state_q <= S_FINAL;
        end
        S_FINAL: begin
          out_data_q  <= round_res;
          out_valid_q <= 1'b1;
          state_q     <= S_HOLD;
        end
        S_HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.key_loaded = key_loaded;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign dbg_state      = state_q;

endmodule
